// File: rtl/imm_extender_pipe.sv
// ============================================================================
// Module      : imm_extender_pipe
// Description : Registered immediate extender. It extends the instruction
//               body at the input according to the immediate-type select,
//               then stores the result in a DEPTH-entry FIFO. Both sides use
//               valid/ready handshakes.
// Config      : Define IMM_CSR_UIMM_EN to make select 5 (CSR rs1 uimm,
//               zero-extended) legal. Without it, select 5 is illegal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extender_pipe #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_imm_src,
  input  logic [24:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_B = PTR_W + 1;
  localparam logic [CNT_B-1:0] C_FULL = CNT_B'(DEPTH);

  // Storage and pointers
  logic [XLEN-1:0]  mem_imm_q [DEPTH];
  logic             mem_err_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_B-1:0] count_q, count_d;
  logic [XLEN-1:0]  out_imm_q, out_imm_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] err_cnt_q;

  // Extension datapath
  logic [31:0]      w_raw;
  logic             w_zext;
  logic             w_illegal;
  logic [XLEN-1:0]  w_sx;
  logic [XLEN-1:0]  w_ext;

  logic             w_push;
  logic             w_pop;

  // Decode the select into a 32-bit immediate, flagging zero-extension or an illegal select
  always_comb begin
    w_raw     = 32'd0;
    w_zext    = 1'b0;
    w_illegal = 1'b0;
    case (in_imm_src)
      3'd0: w_raw = {{20{in_data[24]}}, in_data[24:13]};
      3'd1: w_raw = {{20{in_data[24]}}, in_data[24:18], in_data[4:0]};
      3'd2: w_raw = {{20{in_data[24]}}, in_data[24], in_data[0], in_data[23:18],
                     in_data[4:1], 1'b0};
      3'd3: w_raw = {{12{in_data[24]}}, in_data[24], in_data[12:5], in_data[13],
                     in_data[23:14], 1'b0};
      3'd4: w_raw = {in_data[24:5], 12'd0};
`ifdef IMM_CSR_UIMM_EN
      3'd5: begin
        w_raw  = {27'd0, in_data[12:8]};
        w_zext = 1'b1;
      end
`endif
      default: w_illegal = 1'b1;
    endcase
  end

  // Widen the 32-bit immediate to XLEN; every legal type except CSR uimm sign-extends
  generate
    if (XLEN == 32) begin : g_xlen32
      assign w_sx = w_raw;
    end else begin : g_xlen_wide
      assign w_sx = {{(XLEN-32){w_raw[31] & ~w_zext}}, w_raw};
    end
  endgenerate

  assign w_ext = w_illegal ? '0 : w_sx;

  // Handshakes come from registered state only
  assign in_ready  = (count_q != C_FULL);
  assign out_valid = (count_q != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Next pointers, occupancy and the head value shown next cycle
  always_comb begin
    wr_ptr_d  = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d   = count_q;
    if (w_push && !w_pop) count_d = count_q + CNT_B'(1);
    if (!w_push && w_pop) count_d = count_q - CNT_B'(1);
    out_imm_d = out_imm_q;
    out_err_d = out_err_q;
    if (count_d != '0) begin
      // The new head is the entry being written right now when it lands at rd_ptr_d
      if (w_push && (rd_ptr_d == wr_ptr_q)) begin
        out_imm_d = w_ext;
        out_err_d = w_illegal;
      end else begin
        out_imm_d = mem_imm_q[rd_ptr_d];
        out_err_d = mem_err_q[rd_ptr_d];
      end
    end
  end

  // FIFO state, storage and the registered output head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_imm_q <= '0;
      out_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_imm_q[i] <= '0;
        mem_err_q[i] <= 1'b0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_imm_q <= out_imm_d;
      out_err_q <= out_err_d;
      if (w_push) begin
        mem_imm_q[wr_ptr_q] <= w_ext;
        mem_err_q[wr_ptr_q] <= w_illegal;
      end
    end
  end

  // Saturating count of accepted illegal selects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
    end else if (w_push && w_illegal && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign out_imm = out_imm_q;
  assign out_err = out_err_q;
  assign err_cnt = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_extender_pipe.sv
`default_nettype none

module tb_imm_extender_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  in_imm_src = 3'd0;
  logic [24:0] in_data = 25'd0;
  logic        out_ready = 1'b0;

  logic        a_in_ready, a_out_valid, a_out_err;
  logic [31:0] a_out_imm;
  logic [7:0]  a_err_cnt;
  logic        b_in_ready, b_out_valid, b_out_err;
  logic [63:0] b_out_imm;
  logic [1:0]  b_err_cnt;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;
  int   exp_err = 0;

  always #5 clk = ~clk;

  imm_extender_pipe #(.XLEN(32), .DEPTH(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .in_imm_src(in_imm_src), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_imm(a_out_imm), .out_err(a_out_err), .err_cnt(a_err_cnt)
  );

  imm_extender_pipe #(.XLEN(64), .DEPTH(2), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .in_imm_src(in_imm_src), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_imm(b_out_imm), .out_err(b_out_err), .err_cnt(b_err_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready at the falling edge
  always @(negedge clk) begin
    if (rst_n && a_out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_pop", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_imm_x32", {32'd0, a_out_imm}, {32'd0, e.imm[31:0]});
        check("sb_err_x32", {63'd0, a_out_err}, {63'd0, e.err});
        check("sb_valid_x64", {63'd0, b_out_valid}, 64'd1);
        check("sb_imm_x64", b_out_imm, e.imm);
        check("sb_err_x64", {63'd0, b_out_err}, {63'd0, e.err});
      end
    end
  end

  // Drive one request for one cycle; starts and ends just after a rising edge
  task automatic try_send(input logic [2:0] src, input logic [24:0] d,
                          input logic [31:0] e32, input logic eerr, input logic ezx,
                          output logic acc);
    exp_t e;
    in_valid   = 1'b1;
    in_imm_src = src;
    in_data    = d;
    @(negedge clk);
    acc = a_in_ready;
    @(posedge clk);
    if (acc) begin
      e.imm = ezx ? {32'd0, e32} : {{32{e32[31]}}, e32};
      e.err = eerr;
      sb.push_back(e);
      if (eerr) exp_err++;
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || a_out_valid) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_timeout", {63'd0, (k >= 20)}, 64'd0);
  endtask

  logic acc;

  initial begin
    // Reset state
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
    check("rst_in_ready", {62'd0, a_in_ready, b_in_ready}, 64'd3);
    check("rst_out_imm", {32'd0, a_out_imm} | b_out_imm, 64'd0);
    check("rst_err_cnt", {54'd0, a_err_cnt, b_err_cnt}, 64'd0);

    // I-type with latency check
    out_ready = 1'b1;
    try_send(3'd0, 25'h1000000, 32'hFFFFF800, 1'b0, 1'b0, acc);
    check("lat_out_valid", {63'd0, a_out_valid}, 64'd1);
    check("lat_out_imm", {32'd0, a_out_imm}, 64'hFFFFF800);
    drain();

    // Other types
    try_send(3'd4, 25'h12345 << 5, 32'h12345000, 1'b0, 1'b0, acc);
    try_send(3'd2, 25'h1000000,    32'hFFFFF000, 1'b0, 1'b0, acc);
    try_send(3'd1, 25'h0040002,    32'h00000022, 1'b0, 1'b0, acc);
    try_send(3'd3, 25'h1000000,    32'hFFF00000, 1'b0, 1'b0, acc);
    try_send(3'd3, 25'h0001FE0,    32'h000FF000, 1'b0, 1'b0, acc);
    try_send(3'd0, 25'h0246000,    32'h00000123, 1'b0, 1'b0, acc);
    drain();

    // Full behaviour
    out_ready = 1'b0;
    try_send(3'd0, 25'h0246000, 32'h00000123, 1'b0, 1'b0, acc);
    check("full_acc1", {63'd0, acc}, 64'd1);
    try_send(3'd1, 25'h0040002, 32'h00000022, 1'b0, 1'b0, acc);
    check("full_acc2", {63'd0, acc}, 64'd1);
    check("full_in_ready", {63'd0, a_in_ready}, 64'd0);
    try_send(3'd4, 25'h12345 << 5, 32'h12345000, 1'b0, 1'b0, acc);
    check("full_acc3", {63'd0, acc}, 64'd0);
    out_ready = 1'b1;
    try_send(3'd4, 25'h12345 << 5, 32'h12345000, 1'b0, 1'b0, acc);
    check("full_pop_same_cycle", {63'd0, acc}, 64'd0);
    check("full_ready_after_pop", {63'd0, a_in_ready}, 64'd1);
    try_send(3'd4, 25'h12345 << 5, 32'h12345000, 1'b0, 1'b0, acc);
    check("full_acc_retry", {63'd0, acc}, 64'd1);
    drain();
    check("empty_hold_imm", {32'd0, a_out_imm}, 64'h12345000);
    check("empty_out_valid", {63'd0, a_out_valid}, 64'd0);

    // Illegal selects and saturation
    repeat (3) try_send(3'd7, 25'h1FFFFFF, 32'd0, 1'b1, 1'b0, acc);
    check("ill_cnt3_a", {56'd0, a_err_cnt}, 64'd3);
    check("ill_cnt3_b", {62'd0, b_err_cnt}, 64'd3);
    try_send(3'd6, 25'h1FFFFFF, 32'd0, 1'b1, 1'b0, acc);
    try_send(3'd7, 25'h0000000, 32'd0, 1'b1, 1'b0, acc);
    check("ill_cnt5_a", {56'd0, a_err_cnt}, 64'(exp_err));
    check("ill_cnt_sat_b", {62'd0, b_err_cnt}, 64'd3);

    // CSR uimm select
`ifdef IMM_CSR_UIMM_EN
    try_send(3'd5, 25'h0001F00, 32'h0000001F, 1'b0, 1'b1, acc);
`else
    try_send(3'd5, 25'h0001F00, 32'h00000000, 1'b1, 1'b0, acc);
`endif
    drain();
    check("csr_cnt_a", {56'd0, a_err_cnt}, 64'(exp_err));

    // Reset mid-operation
    out_ready = 1'b0;
    try_send(3'd0, 25'h0246000, 32'h00000123, 1'b0, 1'b0, acc);
    try_send(3'd3, 25'h0001FE0, 32'h000FF000, 1'b0, 1'b0, acc);
    check("mid_held_valid", {63'd0, a_out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {62'd0, a_out_valid, b_out_valid}, 64'd0);
    check("mid_rst_err_cnt", {54'd0, a_err_cnt, b_err_cnt}, 64'd0);
    sb.delete();
    exp_err = 0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", {63'd0, a_in_ready}, 64'd1);
    check("post_rst_out_valid", {63'd0, a_out_valid}, 64'd0);

    // I-type rerun covering XLEN=64
    out_ready = 1'b1;
    try_send(3'd0, 25'h1000000, 32'hFFFFF800, 1'b0, 1'b0, acc);
    check("rerun_imm_x64", b_out_imm, 64'hFFFFFFFFFFFFF800);
    drain();
    check("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
